// File: rtl/spm_pkg.sv
// Shared types and field-width helpers for the banked scratch-pad memory.
package spm_pkg;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_ACC  = 1'b1
    } port_e;

    // Wide enough for any sensible bank count; the top only uses the low bits.
    localparam int unsigned SpmBankIdxW = 8;

    typedef struct packed {
        logic                   valid;
        logic                   err;
        logic [SpmBankIdxW-1:0] bank;
    } spm_resp_t;

    function automatic int unsigned bank_bits(input int unsigned num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int unsigned row_bits(input int unsigned bank_depth);
        return $clog2(bank_depth);
    endfunction

endpackage

// File: rtl/spm_bank.sv
// Synchronous single-port RAM, one bank of the scratch pad. Read data is
// registered; a technology SRAM macro takes its place in synthesis.
module spm_bank
    import spm_pkg::*;
#(
    parameter int unsigned DWidth    = 32,
    parameter int unsigned BankDepth = 1024
) (
    input  logic                          clk_i,
    input  logic                          en_i,
    input  logic                          we_i,
    input  logic [DWidth/8-1:0]           be_i,
    input  logic [row_bits(BankDepth)-1:0] row_i,
    input  logic [DWidth-1:0]             wdata_i,
    output logic [DWidth-1:0]             rdata_o
);

    localparam int unsigned NumBytes = DWidth / 8;

    logic [DWidth-1:0] mem_q [BankDepth];
    logic [DWidth-1:0] rdata_q;

    // Byte-masked write or registered read; contents are never cleared.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < NumBytes; i++) begin
                    if (be_i[i]) begin
                        mem_q[row_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[row_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spm_banked.sv
// Dual-port word-interleaved scratch pad: address decode, per-bank
// round-robin arbitration, bank input muxes and per-port response return.
module spm_banked
    import spm_pkg::*;
#(
    parameter int unsigned DWidth    = 32,
    parameter int unsigned NumBanks  = 4,
    parameter int unsigned BankDepth = 1024,
    parameter int unsigned AWidth    = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                c_req_i,
    input  logic                c_we_i,
    input  logic [AWidth-1:0]   c_addr_i,
    input  logic [DWidth-1:0]   c_wdata_i,
    input  logic [DWidth/8-1:0] c_be_i,
    output logic                c_gnt_o,
    output logic                c_rvalid_o,
    output logic [DWidth-1:0]   c_rdata_o,
    output logic                c_err_o,
    input  logic                a_req_i,
    input  logic                a_we_i,
    input  logic [AWidth-1:0]   a_addr_i,
    input  logic [DWidth-1:0]   a_wdata_i,
    input  logic [DWidth/8-1:0] a_be_i,
    output logic                a_gnt_o,
    output logic                a_rvalid_o,
    output logic [DWidth-1:0]   a_rdata_o,
    output logic                a_err_o
);

    localparam int unsigned BankW = bank_bits(NumBanks);
    localparam int unsigned RowW  = row_bits(BankDepth);
    localparam int unsigned HiLsb = 2 + BankW + RowW;
    localparam int unsigned BeW   = DWidth / 8;

    logic [BankW-1:0] c_bank, a_bank;
    logic [RowW-1:0]  c_row, a_row;
    logic             c_oor, a_oor;

    assign c_bank = c_addr_i[2 +: BankW];
    assign a_bank = a_addr_i[2 +: BankW];
    assign c_row  = c_addr_i[2+BankW +: RowW];
    assign a_row  = a_addr_i[2+BankW +: RowW];
    assign c_oor  = (c_addr_i >> HiLsb) != '0;
    assign a_oor  = (a_addr_i >> HiLsb) != '0;

    logic [NumBanks-1:0] c_hit, a_hit, c_win, a_win;
    port_e               prio_q [NumBanks];
    port_e               prio_d [NumBanks];

    // Per-bank arbitration; the priority bit only matters on a real conflict.
    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            c_hit[b]  = c_req_i && !c_oor && (c_bank == BankW'(b));
            a_hit[b]  = a_req_i && !a_oor && (a_bank == BankW'(b));
            c_win[b]  = c_hit[b] && (!a_hit[b] || prio_q[b] == PORT_CORE);
            a_win[b]  = a_hit[b] && (!c_hit[b] || prio_q[b] == PORT_ACC);
            prio_d[b] = prio_q[b];
            if (c_hit[b] && a_hit[b]) begin
                prio_d[b] = (prio_q[b] == PORT_CORE) ? PORT_ACC : PORT_CORE;
            end
        end
    end

    // Out-of-range requests never touch a bank, so they are always granted.
    assign c_gnt_o = c_req_i && (c_oor || (|c_win));
    assign a_gnt_o = a_req_i && (a_oor || (|a_win));

    // Priority registers hand the next conflict to the port that just lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NumBanks; b++) prio_q[b] <= PORT_CORE;
        end else begin
            for (int b = 0; b < NumBanks; b++) prio_q[b] <= prio_d[b];
        end
    end

    logic [NumBanks-1:0] bk_en, bk_we;
    logic [BeW-1:0]      bk_be    [NumBanks];
    logic [RowW-1:0]     bk_row   [NumBanks];
    logic [DWidth-1:0]   bk_wdata [NumBanks];
    logic [DWidth-1:0]   bk_rdata [NumBanks];

    // Steer the winning port onto each bank.
    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            bk_en[b]    = c_win[b] || a_win[b];
            bk_we[b]    = a_win[b] ? a_we_i    : c_we_i;
            bk_be[b]    = a_win[b] ? a_be_i    : c_be_i;
            bk_row[b]   = a_win[b] ? a_row     : c_row;
            bk_wdata[b] = a_win[b] ? a_wdata_i : c_wdata_i;
        end
    end

    for (genvar g = 0; g < NumBanks; g++) begin : g_bank
        spm_bank #(
            .DWidth    (DWidth),
            .BankDepth (BankDepth)
        ) u_bank (
            .clk_i   (clk_i),
            .en_i    (bk_en[g]),
            .we_i    (bk_we[g]),
            .be_i    (bk_be[g]),
            .row_i   (bk_row[g]),
            .wdata_i (bk_wdata[g]),
            .rdata_o (bk_rdata[g])
        );
    end

    spm_resp_t c_resp_d, c_resp_q, a_resp_d, a_resp_q;

    always_comb begin
        c_resp_d       = '0;
        c_resp_d.valid = c_req_i && c_gnt_o;
        c_resp_d.err   = c_oor;
        c_resp_d.bank  = SpmBankIdxW'(c_bank);
        a_resp_d       = '0;
        a_resp_d.valid = a_req_i && a_gnt_o;
        a_resp_d.err   = a_oor;
        a_resp_d.bank  = SpmBankIdxW'(a_bank);
    end

    // Response trackers; reset drops any response still in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_resp_q <= '0;
            a_resp_q <= '0;
        end else begin
            c_resp_q <= c_resp_d;
            a_resp_q <= a_resp_d;
        end
    end

    assign c_rvalid_o = c_resp_q.valid;
    assign a_rvalid_o = a_resp_q.valid;
    assign c_err_o    = c_resp_q.valid && c_resp_q.err;
    assign a_err_o    = a_resp_q.valid && a_resp_q.err;
    assign c_rdata_o  = (c_resp_q.valid && !c_resp_q.err) ? bk_rdata[c_resp_q.bank[BankW-1:0]] : '0;
    assign a_rdata_o  = (a_resp_q.valid && !a_resp_q.err) ? bk_rdata[a_resp_q.bank[BankW-1:0]] : '0;

    // Word-offset bits and the spare bank-index bits carry no information.
    logic unused_bits;
    assign unused_bits = ^{c_addr_i[1:0], a_addr_i[1:0],
                           c_resp_q.bank[SpmBankIdxW-1:BankW],
                           a_resp_q.bank[SpmBankIdxW-1:BankW]};

endmodule

// File: tb/tb_spm_banked.sv
// Directed scoreboard bench for spm_banked with default parameters.
module tb_spm_banked;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        c_req_i, c_we_i, a_req_i, a_we_i;
    logic [31:0] c_addr_i, c_wdata_i, a_addr_i, a_wdata_i;
    logic [3:0]  c_be_i, a_be_i;
    logic        c_gnt_o, c_rvalid_o, c_err_o, a_gnt_o, a_rvalid_o, a_err_o;
    logic [31:0] c_rdata_o, a_rdata_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t cq[$];
    exp_t aq[$];

    always #5 clk_i = ~clk_i;

    spm_banked u_dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .c_req_i    (c_req_i),
        .c_we_i     (c_we_i),
        .c_addr_i   (c_addr_i),
        .c_wdata_i  (c_wdata_i),
        .c_be_i     (c_be_i),
        .c_gnt_o    (c_gnt_o),
        .c_rvalid_o (c_rvalid_o),
        .c_rdata_o  (c_rdata_o),
        .c_err_o    (c_err_o),
        .a_req_i    (a_req_i),
        .a_we_i     (a_we_i),
        .a_addr_i   (a_addr_i),
        .a_wdata_i  (a_wdata_i),
        .a_be_i     (a_be_i),
        .a_gnt_o    (a_gnt_o),
        .a_rvalid_o (a_rvalid_o),
        .a_rdata_o  (a_rdata_o),
        .a_err_o    (a_err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle on both ports: drive, check grants, queue expected responses.
    task automatic cyc(input string nm,
                       input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic [3:0] cb, input logic cg,
                       input logic [31:0] ce, input logic cerr, input logic cchk,
                       input logic ar, input logic aw, input logic [31:0] aa,
                       input logic [31:0] ad, input logic [3:0] ab, input logic ag,
                       input logic [31:0] ae, input logic aerr, input logic achk);
        @(negedge clk_i);
        c_req_i = cr; c_we_i = cw; c_addr_i = ca; c_wdata_i = cd; c_be_i = cb;
        a_req_i = ar; a_we_i = aw; a_addr_i = aa; a_wdata_i = ad; a_be_i = ab;
        #1;
        if (cr) chk({nm, " c_gnt"}, 32'(c_gnt_o), 32'(cg));
        if (ar) chk({nm, " a_gnt"}, 32'(a_gnt_o), 32'(ag));
        if (cr && cg) cq.push_back('{data: ce, err: cerr, chk_data: cchk});
        if (ar && ag) aq.push_back('{data: ae, err: aerr, chk_data: achk});
        @(posedge clk_i);
    endtask

    task automatic idle();
        cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " c_rvalid"}, 32'(c_rvalid_o), 0);
        chk({nm, " a_rvalid"}, 32'(a_rvalid_o), 0);
        chk({nm, " c_rdata"},  c_rdata_o, 0);
        chk({nm, " a_rdata"},  a_rdata_o, 0);
        chk({nm, " c_err"},    32'(c_err_o), 0);
        chk({nm, " a_err"},    32'(a_err_o), 0);
    endtask

    // Response monitor: pops the scoreboard whenever a port presents rvalid.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (c_rvalid_o) begin
                if (cq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL c_rvalid: got unexpected response, expected none at %0t", $time);
                end else begin
                    exp_t e;
                    e = cq.pop_front();
                    chk("c_err", 32'(c_err_o), 32'(e.err));
                    if (e.chk_data) chk("c_rdata", c_rdata_o, e.data);
                end
            end else begin
                chk("c_rdata idle", c_rdata_o, 0);
            end
            if (a_rvalid_o) begin
                if (aq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL a_rvalid: got unexpected response, expected none at %0t", $time);
                end else begin
                    exp_t e;
                    e = aq.pop_front();
                    chk("a_err", 32'(a_err_o), 32'(e.err));
                    if (e.chk_data) chk("a_rdata", a_rdata_o, e.data);
                end
            end else begin
                chk("a_rdata idle", a_rdata_o, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        c_req_i = 0; c_we_i = 0; c_addr_i = 0; c_wdata_i = 0; c_be_i = 0;
        a_req_i = 0; a_we_i = 0; a_addr_i = 0; a_wdata_i = 0; a_be_i = 0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_all_zero("reset");
        rst_ni = 1'b1;

        //   name          cr cw addr          wdata         be  cg exp          err chk   ar aw addr         wdata        be  ag exp          err chk
        cyc("wr0",        1, 1, 32'h0,      32'hDEADBEEF, 4'hF, 1, 0,            0, 0,   0, 0, 0,          0,          0,   0, 0,            0, 0);
        cyc("rd0",        1, 0, 32'h0,      0,            0,    1, 32'hDEADBEEF, 0, 1,   0, 0, 0,          0,          0,   0, 0,            0, 0);
        cyc("clr8",       1, 1, 32'h8,      32'h0,        4'hF, 1, 0,            0, 0,   0, 0, 0,          0,          0,   0, 0,            0, 0);
        cyc("wr8 be5",    1, 1, 32'h8,      32'h11223344, 4'h5, 1, 0,            0, 0,   0, 0, 0,          0,          0,   0, 0,            0, 0);
        cyc("rd8",        1, 0, 32'h8,      0,            0,    1, 32'h00220044, 0, 1,   0, 0, 0,          0,          0,   0, 0,            0, 0);
        cyc("be0 wr",     1, 1, 32'h0,      32'h0,        4'h0, 1, 0,            0, 0,   1, 1, 32'h4,      32'hCAFEF00D, 4'hF, 1, 0,          0, 0);
        cyc("dual rd",    1, 0, 32'h0,      0,            0,    1, 32'hDEADBEEF, 0, 1,   1, 0, 32'h4,      0,          0,   1, 32'hCAFEF00D, 0, 1);
        cyc("top row wr", 0, 0, 0,          0,            0,    0, 0,            0, 0,   1, 1, 32'h3FFC,   32'hA5A5A5A5, 4'hF, 1, 0,          0, 0);
        cyc("top row rd", 0, 0, 0,          0,            0,    0, 0,            0, 0,   1, 0, 32'h3FFC,   0,          0,   1, 32'hA5A5A5A5, 0, 1);
        cyc("wr10",       1, 1, 32'h10,     32'h12345678, 4'hF, 1, 0,            0, 0,   0, 0, 0,          0,          0,   0, 0,            0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc("conflict", 1, 0, 32'h10, 0, 0, (i % 2 == 0), 32'h12345678, 0, 1,
                            1, 0, 32'h10, 0, 0, (i % 2 == 1), 32'h12345678, 0, 1);
        end
        cyc("oor wr",     0, 0, 0,          0,            0,    0, 0,            0, 0,   1, 1, 32'h4000,   32'hFFFFFFFF, 4'hF, 1, 0,          1, 1);
        cyc("oor rd",     0, 0, 0,          0,            0,    0, 0,            0, 0,   1, 0, 32'h4000,   0,          0,   1, 0,            1, 1);
        cyc("oor vs bank",1, 1, 32'h4000,   32'h0,        4'hF, 1, 0,            1, 1,   1, 0, 32'h0,      0,          0,   1, 32'hDEADBEEF, 0, 1);
        cyc("conflict pre",1, 0, 32'h10,    0,            0,    1, 32'h12345678, 0, 1,   1, 0, 32'h10,     0,          0,   0, 0,            0, 0);
        idle();

        // Read accepted, then reset lands before the response edge.
        @(negedge clk_i);
        c_req_i = 1; c_we_i = 0; c_addr_i = 32'h0;
        #1;
        chk("rst rd c_gnt", 32'(c_gnt_o), 1);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        chk_all_zero("in reset");
        @(negedge clk_i);
        c_req_i = 0;
        rst_ni = 1'b1;
        #1;
        chk_all_zero("after reset");

        cyc("post rst c", 1, 0, 32'h10,     0,            0,    1, 32'h12345678, 0, 1,   1, 0, 32'h10,     0,          0,   0, 0,            0, 0);
        cyc("post rst a", 1, 0, 32'h10,     0,            0,    0, 0,            0, 0,   1, 0, 32'h10,     0,          0,   1, 32'h12345678, 0, 1);
        idle();
        idle();

        chk("c queue drained", 32'(cq.size()), 0);
        chk("a queue drained", 32'(aq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spm_banked.md
# spm_banked

Parametrised, dual-port, word-interleaved scratch-pad memory for the MLP accelerator. It replaces the single-port 8-bit scratch pad with full-width banked storage that the scalar core port and the accelerator port share. Each bank has its own round-robin arbiter, writes honour byte strobes, and read data returns with a fixed one-cycle latency and a valid flag.

## Interface
- DWidth, 32: data word width; must be a multiple of 8.
- NumBanks, 4: number of banks; power of two, at least 2.
- BankDepth, 1024: words per bank; power of two.
- AWidth, 32: byte-address width of both ports.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- c_req_i / a_req_i  in  1  request from the core port / accelerator port.
- c_we_i / a_we_i  in  1  1 = write, 0 = read.
- c_addr_i / a_addr_i  in  AWidth  byte address; bits [1:0] are ignored (word aligned).
- c_wdata_i / a_wdata_i  in  DWidth  write data.
- c_be_i / a_be_i  in  DWidth/8  byte write enables.
- c_gnt_o / a_gnt_o  out  1  combinational grant; the request is accepted in a cycle where req && gnt.
- c_rvalid_o / a_rvalid_o  out  1  response valid, for both reads and writes.
- c_rdata_o / a_rdata_o  out  DWidth  read data; 0 whenever rvalid is low.
- c_err_o / a_err_o  out  1  out-of-range access flag; only meaningful while rvalid is high.

## Operation
- Address decode:
  - bank = addr[2 +: log2(NumBanks)].
  - row = addr[2+log2(NumBanks) +: log2(BankDepth)].
  - Any set bit above the row field makes the access out of range.
- No conflict: ports addressing different banks are both granted in the same cycle.
- Conflict: both ports request the same in-range bank.
  - The port holding priority for that bank wins; the other sees gnt = 0 and must hold req, we, addr, wdata and be stable.
  - Each bank keeps a 1-bit priority register, reset to core.
  - On a granted conflict, that bank's priority flips to the losing port.
  - Non-conflicting grants leave the priority unchanged.
- Out-of-range access:
  - It is always granted and touches no bank.
  - No write occurs; the response has rdata = 0 and err = 1.
- Write: in the grant cycle, bytes with be[i] = 1 are written into bank[row]; other bytes are unchanged. be = 0 is legal, writes nothing, and still produces a response.
- Read-during-write: a read granted in the same cycle as a write to the same word cannot happen, because there is a single grant per bank per cycle.
- A read issued in the cycle after a write to the same word returns the new data.
- Each port registers the bank index and err bit of its granted request, to steer and flag its response.

## Timing
- Grant: combinational from req and addr of both ports plus the priority registers, with no dependence on outputs.
- Response: exactly one cycle after the accepted cycle; rvalid = 1 for one cycle per accepted request.
- Back-to-back accepted requests on a port give back-to-back rvalid pulses.
- Throughput: one access per port per cycle when the ports do not conflict.
- Reset values: all rvalid 0, rdata 0, err 0; all priority bits select core.
- Memory contents are undefined after reset; a bank array is not cleared.
- Reset asserted while a response is pending: the response is dropped and no rvalid is produced after release.
- A write accepted in the cycle reset asserts is not guaranteed to take effect.

## Structure
- Shared package spm_pkg holds:
  - the port-select enum port_e {PORT_CORE, PORT_ACC};
  - the response struct {valid, err, bank};
  - localparam helper functions for the bank and row field widths.
- One sub-module, spm_bank: a synchronous single-port RAM of BankDepth x DWidth.
  - Inputs: enable, write enable, byte strobes, row, write data.
  - Output: registered read data.
  - It is instantiated NumBanks times through a generate loop.
  - A technology SRAM macro replaces it in synthesis.
- Top level: address decode, per-bank arbiters and priority registers, bank input muxes, per-port response registers, and the rdata return mux.

## Test plan
- Core writes 0xDEADBEEF to 0x0 with be = 0xF, then reads 0x0 → gnt in the same cycle; rvalid the next cycle with rdata 0xDEADBEEF, err 0.
- Core writes 0x11223344 to 0x8 with be = 0x5, then reads 0x8 → previous word 0 gives 0x00220044.
- With NumBanks = 4, core reads 0x0 and accelerator reads 0x4 in the same cycle → both granted; both rvalid the next cycle with the correct data.
- Both ports hold req to 0x10 for 4 cycles → grants alternate core, acc, core, acc, with exactly one rvalid per accepted request.
- Accelerator writes 0xFFFFFFFF to byte address NumBanks·BankDepth·4 and reads it back → granted; rvalid with err 1 and rdata 0; a subsequent read of 0x0 is unchanged.
- Read accepted, then rst_ni pulsed low before the response cycle → no rvalid; all outputs 0 and priorities reset to core; the first post-reset conflict is won by core.
